// File: rtl/fp_icvt_pipe_if.sv
// fp_icvt_pipe_if: operation/result stream bundle for the integer-to-float32
// converter.
//   in_valid/in_ready   : operation handshake
//   in_data             : IN_W-bit integer pattern
//   in_signed           : 1 = two's-complement input, 0 = unsigned input
//   in_rm               : 0 = round-to-nearest-even, 1 = round-toward-zero
//   in_tag              : opaque tag that travels with the operation
//   out_valid/out_ready : result handshake
//   out_data            : IEEE-754 single-precision result
//   out_inexact         : result differs from the exact integer value
//   out_tag             : tag of the result
// master = issue side / consumer, slave = converter.
`timescale 1ns/1ps
interface fp_icvt_pipe_if #(
    parameter int IN_W  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_signed;
    logic             in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_inexact;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_signed, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_tag
    );
endinterface

// File: rtl/fp_icvt_pipe.sv
// fp_icvt_pipe: three-stage pipelined integer (IN_W = 8..64) to float32
// converter with per-operation signed/unsigned selection, RNE/RTZ rounding,
// inexact flag and a pass-through tag. Valid/ready on both sides, full
// throughput under backpressure.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; empties the pipe and zeroes outputs
//   bus   : fp_icvt_pipe_if slave modport (operation in, result out)
`timescale 1ns/1ps
module fp_icvt_pipe #(
    parameter int IN_W  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_icvt_pipe_if.slave bus
);
    localparam int PW = $clog2(IN_W);
    // Normalised magnitude padded with zeros so fraction/guard/sticky can be
    // sliced at fixed offsets even when IN_W has fewer than 25 bits.
    localparam int EW = IN_W + 24;

    // Position of the most significant set bit (0 when v is zero).
    function automatic logic [PW-1:0] lead_pos(input logic [IN_W-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (v[i]) p = PW'(i);
        end
        return p;
    endfunction

    // Round a left-justified magnitude and pack it; returns {inexact, float32}.
    function automatic logic [32:0] round_pack(
        input logic [IN_W-1:0] norm,
        input logic [PW-1:0]   pos,
        input logic            sign,
        input logic            zero,
        input logic            rtz
    );
        logic [EW-1:0] ext;
        logic [22:0]   frac;
        logic          guard;
        logic          sticky;
        logic          inc;
        logic [23:0]   sum;
        logic [7:0]    expo;
        ext    = {norm, 24'd0};
        frac   = ext[EW-2 -: 23];
        guard  = ext[EW-25];
        sticky = |ext[EW-26:0];
        inc    = ~rtz & guard & (sticky | frac[0]);
        sum    = {1'b0, frac} + 24'(inc);
        expo   = 8'd127 + 8'(pos);
        // A carry out of the fraction leaves sum[22:0] at zero already.
        if (sum[23]) expo = expo + 8'd1;
        if (zero) return 33'd0;
        return {guard | sticky, sign, expo, sum[22:0]};
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic              adv0, adv1, adv2;

    logic              sign_p0, rm_p0;
    logic [IN_W-1:0]   mag_p0;
    logic [TAG_W-1:0]  tag_p0;

    logic              sign_p1, rm_p1, zero_p1;
    logic [IN_W-1:0]   norm_p1;
    logic [PW-1:0]     pos_p1;
    logic [TAG_W-1:0]  tag_p1;

    logic [31:0]       data_p2;
    logic              inexact_p2;
    logic [TAG_W-1:0]  tag_p2;

    logic signed [IN_W-1:0] sdata;
    logic                   neg;
    logic [IN_W-1:0]        mag;
    logic [PW-1:0]          pos0;

    // A stage loads when it is empty or its occupant moves on this cycle.
    assign adv2 = ~vld_p2 | bus.out_ready;
    assign adv1 = ~vld_p1 | adv2;
    assign adv0 = ~vld_p0 | adv1;

    assign bus.in_ready = rst_n & adv0;

    always_comb begin
        sdata = bus.in_data;
        neg   = bus.in_signed & sdata[IN_W-1];
        // Negating the most negative value wraps to 2^(IN_W-1), which is the
        // correct unsigned magnitude.
        mag   = neg ? IN_W'(-sdata) : bus.in_data;
        pos0  = lead_pos(mag_p0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv0) vld_p0 <= bus.in_valid;
            if (adv1) vld_p1 <= vld_p0;
            if (adv2) vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        // ---- S1: sign / magnitude ----
        if (adv0 && bus.in_valid) begin
            sign_p0 <= neg;
            mag_p0  <= mag;
            rm_p0   <= bus.in_rm;
            tag_p0  <= bus.in_tag;
        end
        // ---- S2: normalise (leading one to bit IN_W-1) ----
        if (adv1 && vld_p0) begin
            sign_p1 <= sign_p0;
            norm_p1 <= mag_p0 << (PW'(IN_W - 1) - pos0);
            pos_p1  <= pos0;
            zero_p1 <= (mag_p0 == '0);
            rm_p1   <= rm_p0;
            tag_p1  <= tag_p0;
        end
    end

    // ---- S3: round and pack; held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2    <= '0;
            inexact_p2 <= 1'b0;
            tag_p2     <= '0;
        end else if (adv2 && vld_p1) begin
            {inexact_p2, data_p2} <= round_pack(norm_p1, pos_p1, sign_p1, zero_p1, rm_p1);
            tag_p2                <= tag_p1;
        end
    end

    assign bus.out_valid   = vld_p2;
    assign bus.out_data    = data_p2;
    assign bus.out_inexact = inexact_p2;
    assign bus.out_tag     = tag_p2;
endmodule

// File: tb/tb_fp_icvt_pipe.sv
// tb_fp_icvt_pipe: bench for fp_icvt_pipe at IN_W = 32, 64 and 8.
`timescale 1ns/1ps
module tb_fp_icvt_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    fp_icvt_pipe_if #(.IN_W(32), .TAG_W(5)) i32 ();
    fp_icvt_pipe_if #(.IN_W(64), .TAG_W(5)) i64 ();
    fp_icvt_pipe_if #(.IN_W(8),  .TAG_W(5)) i8  ();

    fp_icvt_pipe #(.IN_W(32), .TAG_W(5)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
    fp_icvt_pipe #(.IN_W(64), .TAG_W(5)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));
    fp_icvt_pipe #(.IN_W(8),  .TAG_W(5)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] x;
        int          w;
        bit          sgn;
        bit          rtz;
        logic [31:0] d;
        bit          inx;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int w, input logic [63:0] x, input bit sgn, input bit rtz,
                       input logic [31:0] d, input bit inx);
        vec_t v;
        v.x = x; v.w = w; v.sgn = sgn; v.rtz = rtz; v.d = d; v.inx = inx;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Reference: value arithmetic on the magnitude -- divide by the unit in the
    // last place, compare the remainder with half of it. Returns {inexact, float}.
    function automatic logic [32:0] ref_cvt(input logic [63:0] xin, input int w,
                                            input bit sgn, input bit rtz);
        logic [63:0]     mask;
        logic [63:0]     x;
        longint unsigned mag, q, rem, unit, half;
        bit              neg, inx;
        int              e;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x    = xin & mask;
        neg  = sgn && x[w-1];
        mag  = neg ? ((~x + 64'd1) & mask) : x;
        if (mag == 0) return 33'd0;
        e = 63;
        while ((mag >> e) == 0) e--;
        inx = 1'b0;
        if (e <= 23) begin
            q = mag << (23 - e);
        end else begin
            unit = 64'd1 << (e - 23);
            half = unit >> 1;
            q    = mag / unit;
            rem  = mag % unit;
            inx  = (rem != 0);
            if (!rtz && (rem > half || (rem == half && q[0]))) q++;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
        end
        return {inx, neg, 8'(e + 127), q[22:0]};
    endfunction

    function automatic logic [38:0] outs(input int w);
        case (w)
            8:       return {i8.out_valid,  i8.out_inexact,  i8.out_tag,  i8.out_data};
            64:      return {i64.out_valid, i64.out_inexact, i64.out_tag, i64.out_data};
            default: return {i32.out_valid, i32.out_inexact, i32.out_tag, i32.out_data};
        endcase
    endfunction

    // Single operation with out_ready held high; checks latency and result.
    task automatic run_op(input int w, input logic [63:0] x, input bit sgn, input bit rtz,
                          input logic [4:0] tag, input logic [31:0] ed, input bit ei,
                          input string nm);
        int          lat;
        logic [38:0] o;
        case (w)
            8: begin
                i8.in_valid = 1'b1; i8.in_data = x[7:0]; i8.in_signed = sgn;
                i8.in_rm = rtz; i8.in_tag = tag;
            end
            64: begin
                i64.in_valid = 1'b1; i64.in_data = x; i64.in_signed = sgn;
                i64.in_rm = rtz; i64.in_tag = tag;
            end
            default: begin
                i32.in_valid = 1'b1; i32.in_data = x[31:0]; i32.in_signed = sgn;
                i32.in_rm = rtz; i32.in_tag = tag;
            end
        endcase
        @(posedge clk); #1;
        i8.in_valid = 1'b0; i64.in_valid = 1'b0; i32.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            o = outs(w);
            if (o[38]) begin lat = k; break; end
            @(posedge clk); #1;
        end
        o = outs(w);
        chk($sformatf("%s_lat", nm), lat, 3);
        chk($sformatf("%s_data", nm), o[31:0], ed);
        chk($sformatf("%s_inx", nm), o[37], ei);
        chk($sformatf("%s_tag", nm), o[36:32], tag);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 600)) - 32'd300;
            2:       v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 4)) - 32'd2;
            3:       v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // Random valid/ready traffic on the 32-bit unit against a scoreboard.
    task automatic rand_stream(input int nops);
        logic [37:0] sb[$];
        logic [37:0] e;
        logic [32:0] r;
        int          sent;
        sent = 0;
        for (int cyc = 0; cyc < 4000 && (sent < nops || sb.size() != 0); cyc++) begin
            if (sent < nops && $urandom_range(0, 3) != 0) begin
                i32.in_valid  = 1'b1;
                i32.in_data   = rand_operand();
                i32.in_signed = 1'($urandom);
                i32.in_rm     = 1'($urandom);
                i32.in_tag    = 5'($urandom);
            end else begin
                i32.in_valid = 1'b0;
            end
            i32.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i32.in_valid && i32.in_ready) begin
                r = ref_cvt({32'd0, i32.in_data}, 32, i32.in_signed, i32.in_rm);
                sb.push_back({r[32], i32.in_tag, r[31:0]});
                sent++;
            end
            if (i32.out_valid && i32.out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_extra", i32.out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_out", {i32.out_inexact, i32.out_tag, i32.out_data}, e);
                end
            end
            @(posedge clk); #1;
        end
        i32.in_valid  = 1'b0;
        i32.out_ready = 1'b1;
        chk("rnd_drain", sb.size(), 0);
        chk("rnd_sent", sent, nops);
    endtask

    // 8 back-to-back operations, consumer stalled for the first 5 cycles.
    task automatic bp_test();
        logic [31:0] ops[8];
        logic [37:0] expq[8];
        logic [32:0] r;
        logic [31:0] held;
        bit          stall_prev;
        int          sent, got, first, last;
        for (int i = 0; i < 8; i++) begin
            ops[i]  = 32'h0123_4567 * 32'(i + 3) + 32'(i * 77);
            r       = ref_cvt({32'd0, ops[i]}, 32, i[0], 1'b0);
            expq[i] = {r[32], 5'(i + 1), r[31:0]};
        end
        sent = 0; got = 0; first = -1; last = -1; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            i32.out_ready = (cyc >= 5);
            if (sent < 8) begin
                i32.in_valid  = 1'b1;
                i32.in_data   = ops[sent];
                i32.in_signed = sent[0];
                i32.in_rm     = 1'b0;
                i32.in_tag    = 5'(sent + 1);
            end else begin
                i32.in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_accepts", sent, 3);
                chk("bp_in_ready", i32.in_ready, 1'b0);
            end
            if (stall_prev && i32.out_valid) chk("bp_hold", i32.out_data, held);
            stall_prev = i32.out_valid && !i32.out_ready;
            held       = i32.out_data;
            if (i32.in_valid && i32.in_ready) sent++;
            if (i32.out_valid && i32.out_ready) begin
                chk($sformatf("bp_out%0d", got), {i32.out_inexact, i32.out_tag, i32.out_data}, expq[got]);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
        end
        i32.in_valid  = 1'b0;
        i32.out_ready = 1'b1;
        chk("bp_count", got, 8);
        chk("bp_rate", last - first, 7);
    endtask

    task automatic reset_test();
        bit stale;
        i32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i32.in_valid  = 1'b1;
            i32.in_data   = 32'h0100_0001 + 32'(i);
            i32.in_signed = 1'b0;
            i32.in_rm     = 1'b0;
            i32.in_tag    = 5'(i + 7);
            @(posedge clk); #1;
        end
        i32.in_valid = 1'b0;
        chk("rst_pre_valid", i32.out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", i32.out_valid, 1'b0);
        chk("rst_async_data", i32.out_data, 32'h0);
        chk("rst_async_inx", i32.out_inexact, 1'b0);
        chk("rst_async_tag", i32.out_tag, 5'd0);
        chk("rst_in_ready", i32.in_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        i32.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i32.out_valid) stale = 1'b1;
        end
        @(posedge clk); #1;
        chk("rst_stale", stale, 1'b0);
        run_op(32, 64'd1, 1'b1, 1'b0, 5'd9, 32'h3F80_0000, 1'b0, "rst_next");
    endtask

    initial begin
        logic [63:0] x;
        logic [32:0] r;
        bit          s, m;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b1;
        i32.in_valid = 1'b0; i32.in_data = '0; i32.in_signed = 1'b0; i32.in_rm = 1'b0;
        i32.in_tag = '0; i32.out_ready = 1'b1;
        i64.in_valid = 1'b0; i64.in_data = '0; i64.in_signed = 1'b0; i64.in_rm = 1'b0;
        i64.in_tag = '0; i64.out_ready = 1'b1;
        i8.in_valid = 1'b0; i8.in_data = '0; i8.in_signed = 1'b0; i8.in_rm = 1'b0;
        i8.in_tag = '0; i8.out_ready = 1'b1;

        #3 rst_n = 1'b0;
        #1;
        chk("reset_valid", i32.out_valid, 1'b0);
        chk("reset_data", i32.out_data, 32'h0);
        chk("reset_tag", i32.out_tag, 5'd0);
        chk("reset_in_ready", i32.in_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", i32.in_ready, 1'b1);
        @(posedge clk); #1;

        add(32, 64'h0000_0000, 1, 0, 32'h0000_0000, 0);
        add(32, 64'h0000_0001, 1, 0, 32'h3F80_0000, 0);
        add(32, 64'hFFFF_FFFF, 1, 0, 32'hBF80_0000, 0);
        add(32, 64'hFFFF_FF00, 1, 0, 32'hC380_0000, 0);
        add(32, 64'h0100_0000, 1, 0, 32'h4B80_0000, 0);
        add(32, 64'h8000_0000, 1, 0, 32'hCF00_0000, 0);
        add(32, 64'h0100_0001, 1, 0, 32'h4B80_0000, 1);
        add(32, 64'h0100_0003, 1, 0, 32'h4B80_0002, 1);
        add(32, 64'h0100_0003, 1, 1, 32'h4B80_0001, 1);
        add(32, 64'h7FFF_FFFF, 1, 0, 32'h4F00_0000, 1);
        add(32, 64'h7FFF_FFFF, 1, 1, 32'h4EFF_FFFF, 1);
        add(32, 64'hFFFF_FFFF, 0, 0, 32'h4F80_0000, 1);
        add(64, 64'h8000_0000_0000_0000, 1, 0, 32'hDF00_0000, 0);
        add(64, 64'h0020_0000_0000_0001, 0, 0, 32'h5A00_0000, 1);
        add(8,  64'h80, 1, 0, 32'hC300_0000, 0);
        add(8,  64'hFF, 0, 0, 32'h437F_0000, 0);
        add(8,  64'hFF, 1, 0, 32'hBF80_0000, 0);

        foreach (tbl[i])
            run_op(tbl[i].w, tbl[i].x, tbl[i].sgn, tbl[i].rtz, 5'(i), tbl[i].d, tbl[i].inx,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            x = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
            s = 1'($urandom); m = 1'($urandom);
            r = ref_cvt(x, 64, s, m);
            run_op(64, x, s, m, 5'($urandom), r[31:0], r[32], "r64");
            x = 64'($urandom_range(0, 255));
            s = 1'($urandom); m = 1'($urandom);
            r = ref_cvt(x, 8, s, m);
            run_op(8, x, s, m, 5'($urandom), r[31:0], r[32], "r8");
        end

        bp_test();
        rand_stream(300);
        reset_test();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
